// File: rtl/i2c_target.sv
// I2C/SCCB target: decodes START/STOP, matches a 7-bit address and serves a 256 x 8
// register file with auto-incrementing pointer; SDA is driven open-drain via sda_oe_o.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR  = 7'h21,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o,
  output logic [3:0] state_o
);

  // wr_valid_o is a one-cycle strobe with no back-pressure (no ready); wr_addr_o and
  // wr_data_o become valid with it and stay stable until the next strobe.

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DEV     = 4'd1,
    S_DEV_ACK = 4'd2,
    S_REG     = 4'd3,
    S_REG_ACK = 4'd4,
    S_WR      = 4'd5,
    S_WR_ACK  = 4'd6,
    S_RD      = 4'd7,
    S_MACK    = 4'd8,
    S_IGNORE  = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic       scl_s1, scl_s2, scl_q;
  logic       sda_s1, sda_s2, sda_q;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] in_byte, rd_byte;
  logic       byte_done, oe_d, commit;
  logic [7:0] regs [256];

  // Bus idles high, so the synchronisers reset to 1 to avoid phantom edges.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      {scl_s1, scl_s2, scl_q} <= 3'b111;
      {sda_s1, sda_s2, sda_q} <= 3'b111;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_q  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_q  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_q;
  assign scl_fall  = ~scl_s2 & scl_q;
  assign start_det = scl_s2 & scl_q & sda_q & ~sda_s2;
  assign stop_det  = scl_s2 & scl_q & ~sda_q & sda_s2;
  assign in_byte   = {shreg_q[6:0], sda_s2};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
  assign rd_byte   = regs[ptr_q];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // In the ACK states sda_oe_o doubles as the phase flag: the first SCL fall starts
  // the ACK drive, the second one ends it.
  always_comb begin
    state_d = state_q;
    if (start_det) state_d = S_DEV;
    else if (stop_det) state_d = S_IDLE;
    else begin
      case (state_q)
        S_DEV:     if (byte_done) state_d = (in_byte[7:1] == DEV_ADDR) ? S_DEV_ACK : S_IGNORE;
        S_DEV_ACK: if (scl_fall && sda_oe_o) state_d = shreg_q[0] ? S_RD : S_REG;
        S_REG:     if (byte_done) state_d = S_REG_ACK;
        S_REG_ACK: if (scl_fall && sda_oe_o) state_d = S_WR;
        S_WR:      if (byte_done) state_d = S_WR_ACK;
        S_WR_ACK:  if (scl_fall && sda_oe_o) state_d = S_WR;
        S_RD:      if (scl_fall && (bit_cnt_q == 3'd7)) state_d = S_MACK;
        S_MACK: begin
          if (scl_rise && sda_s2) state_d = S_IGNORE;
          else if (scl_fall && (bit_cnt_q == 3'd1)) state_d = S_RD;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // In MACK, bit_cnt = 1 records a master ACK so the next SCL fall starts a new byte.
  always_comb begin
    oe_d      = sda_oe_o;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    commit    = 1'b0;
    if (start_det) begin
      oe_d      = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (stop_det) begin
      oe_d = 1'b0;
    end else begin
      case (state_q)
        S_DEV, S_REG, S_WR: begin
          if (scl_rise) begin
            shreg_d   = in_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == S_REG) ptr_d = in_byte;
              if (state_q == S_WR) begin
                commit = 1'b1;
                ptr_d  = ptr_q + 8'd1;
              end
            end
          end
        end
        S_DEV_ACK, S_REG_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_o) oe_d = 1'b1;
            else if ((state_q == S_DEV_ACK) && shreg_q[0]) begin
              oe_d      = ~rd_byte[7];
              shreg_d   = {rd_byte[6:0], 1'b0};
              bit_cnt_d = 3'd0;
            end else oe_d = 1'b0;
          end
        end
        S_RD: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              oe_d      = 1'b0;
              bit_cnt_d = 3'd0;
            end else begin
              oe_d      = ~shreg_q[7];
              shreg_d   = {shreg_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        S_MACK: begin
          if (scl_rise && !sda_s2) begin
            ptr_d     = ptr_q + 8'd1;
            bit_cnt_d = 3'd1;
          end else if (scl_fall && (bit_cnt_q == 3'd1)) begin
            oe_d      = ~rd_byte[7];
            shreg_d   = {rd_byte[6:0], 1'b0};
            bit_cnt_d = 3'd0;
          end
        end
        default: oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sda_oe_o   <= 1'b0;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      ptr_q      <= 8'h00;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= 8'h00;
      wr_data_o  <= 8'h00;
    end else begin
      sda_oe_o   <= oe_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ptr_q      <= ptr_d;
      wr_valid_o <= commit;
      if (commit) begin
        wr_addr_o <= ptr_q;
        wr_data_o <= in_byte;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < 256; i++) regs[i] <= RESET_VAL;
    end else if (commit) begin
      regs[ptr_q] <= in_byte;
    end
  end

  assign busy_o  = (state_q != S_IDLE) && (state_q != S_IGNORE);
  assign state_o = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master drives the bus and a
// scoreboard matches every wr_valid_o strobe against queued expected writes.
module tb_i2c_target;

  localparam logic [7:0] ST_IDLE   = 8'd0;
  localparam logic [7:0] ST_IGNORE = 8'd9;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data;
  logic [3:0] state;
  logic       sda_line;

  int n_vec = 0;
  int n_err = 0;
  int oe_seen = 0;
  logic watch_oe = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_oe_o   (sda_oe),
    .wr_valid_o (wr_valid),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .busy_o     (busy),
    .state_o    (state)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: each committed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n && wr_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_commit: unexpected write addr=%h data=%h", wr_addr, wr_data);
      end else begin
        logic [15:0] exp;
        exp = exp_q.pop_front();
        if ({wr_addr, wr_data} !== exp) begin
          n_err++;
          $display("FAIL wr_commit: got addr=%h data=%h expected addr=%h data=%h",
                   wr_addr, wr_data, exp[15:8], exp[7:0]);
        end
      end
    end
  end

  always @(negedge clk) if (watch_oe && sda_oe) oe_seen++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clk(5);
    scl_m = 1'b1;
    wait_clk(10);
    sda_m = 1'b0;
    wait_clk(10);
    scl_m = 1'b0;
    wait_clk(5);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clk(5);
    scl_m = 1'b1;
    wait_clk(10);
    sda_m = 1'b1;
    wait_clk(10);
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    sda_m = b;
    wait_clk(5);
    scl_m = 1'b1;
    wait_clk(5);
    seen = sda_line;
    wait_clk(5);
    scl_m = 1'b0;
    wait_clk(5);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic master_ack);
    logic s;
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~master_ack, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] rb;
    logic [7:0] addr_w;

    wait_clk(4);
    check1("rst_sda_oe", sda_oe, 1'b0);
    check1("rst_wr_valid", wr_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check8("rst_wr_addr", wr_addr, 8'h00);
    check8("rst_wr_data", wr_data, 8'h00);
    check8("rst_state", {4'h0, state}, ST_IDLE);
    reset_n = 1'b1;
    wait_clk(10);

    // Seed reg[01] so a later current-address read can prove the wrapped pointer.
    bus_start();
    send_byte(8'h42, ack); check1("seed_addr_ack", ack, 1'b1);
    send_byte(8'h01, ack); check1("seed_ptr_ack", ack, 1'b1);
    exp_q.push_back({8'h01, 8'h3C});
    send_byte(8'h3C, ack); check1("seed_data_ack", ack, 1'b1);
    bus_stop();

    // Single write: 0x42, 0x12, 0xA5.
    bus_start();
    send_byte(8'h42, ack); check1("wr_addr_ack", ack, 1'b1);
    check1("wr_busy", busy, 1'b1);
    send_byte(8'h12, ack); check1("wr_ptr_ack", ack, 1'b1);
    exp_q.push_back({8'h12, 8'hA5});
    send_byte(8'hA5, ack); check1("wr_data_ack", ack, 1'b1);
    bus_stop();
    wait_clk(5);
    check8("wr_state_idle", {4'h0, state}, ST_IDLE);
    check1("wr_busy_after_stop", busy, 1'b0);
    check8("wr_addr_hold", wr_addr, 8'h12);
    check8("wr_data_hold", wr_data, 8'hA5);

    // Combined read: pointer 0x12, repeated START, read A5 then reg[13].
    bus_start();
    send_byte(8'h42, ack); check1("cr_addr_ack", ack, 1'b1);
    send_byte(8'h12, ack); check1("cr_ptr_ack", ack, 1'b1);
    bus_start();
    send_byte(8'h43, ack); check1("cr_rd_addr_ack", ack, 1'b1);
    read_byte(rb, 1'b1); check8("cr_byte0", rb, 8'hA5);
    read_byte(rb, 1'b0); check8("cr_byte1", rb, 8'h00);
    check8("cr_state_ignore", {4'h0, state}, ST_IGNORE);
    check1("cr_sda_released", sda_oe, 1'b0);
    check1("cr_busy_ignore", busy, 1'b0);
    bus_stop();
    wait_clk(5);
    check8("cr_state_idle", {4'h0, state}, ST_IDLE);

    // Burst write wrapping FE, FF, 00.
    bus_start();
    send_byte(8'h42, ack); check1("bw_addr_ack", ack, 1'b1);
    send_byte(8'hFE, ack); check1("bw_ptr_ack", ack, 1'b1);
    exp_q.push_back({8'hFE, 8'h01});
    send_byte(8'h01, ack); check1("bw_d0_ack", ack, 1'b1);
    exp_q.push_back({8'hFF, 8'h02});
    send_byte(8'h02, ack); check1("bw_d1_ack", ack, 1'b1);
    exp_q.push_back({8'h00, 8'h03});
    send_byte(8'h03, ack); check1("bw_d2_ack", ack, 1'b1);
    bus_stop();
    check8("bw_last_addr", wr_addr, 8'h00);
    check8("bw_last_data", wr_data, 8'h03);

    // Current-address read must start at pointer 0x01 (seeded with 3C).
    bus_start();
    send_byte(8'h43, ack); check1("bw_rd_addr_ack", ack, 1'b1);
    read_byte(rb, 1'b0); check8("bw_ptr_wrapped", rb, 8'h3C);
    bus_stop();

    // Read across the FF -> 00 wrap.
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'hFF, ack);
    bus_start();
    send_byte(8'h43, ack); check1("wrap_rd_addr_ack", ack, 1'b1);
    read_byte(rb, 1'b1); check8("wrap_rd_ff", rb, 8'h02);
    read_byte(rb, 1'b0); check8("wrap_rd_00", rb, 8'h03);
    bus_stop();

    // Address mismatch: target must stay silent.
    oe_seen  = 0;
    watch_oe = 1'b1;
    bus_start();
    send_byte(8'h44, ack); check1("mm_addr_nack", ack, 1'b0);
    check1("mm_busy", busy, 1'b0);
    check8("mm_state_ignore", {4'h0, state}, ST_IGNORE);
    send_byte(8'h12, ack); check1("mm_ptr_nack", ack, 1'b0);
    send_byte(8'h55, ack); check1("mm_data_nack", ack, 1'b0);
    bus_stop();
    watch_oe = 1'b0;
    check8("mm_oe_never", oe_seen[7:0], 8'h00);
    check8("mm_state_idle", {4'h0, state}, ST_IDLE);

    // STOP after 4 data bits: no commit, pointer stays 0x20.
    bus_start();
    send_byte(8'h42, ack); check1("sm_addr_ack", ack, 1'b1);
    send_byte(8'h20, ack); check1("sm_ptr_ack", ack, 1'b1);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    clock_bit(1'b1, s);
    bus_stop();
    wait_clk(5);
    check8("sm_state_idle", {4'h0, state}, ST_IDLE);
    check8("sm_addr_unchanged", wr_addr, 8'h00);
    bus_start();
    send_byte(8'h43, ack); check1("sm_rd_addr_ack", ack, 1'b1);
    read_byte(rb, 1'b0); check8("sm_rd_reset_val", rb, 8'h00);
    bus_stop();

    // Reset while the address ACK is being driven.
    addr_w = 8'h42;
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(addr_w[i], s);
    check1("rma_ack_driving", sda_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    check1("rma_oe_released", sda_oe, 1'b0);
    check1("rma_busy", busy, 1'b0);
    check8("rma_state", {4'h0, state}, ST_IDLE);
    check8("rma_wr_addr", wr_addr, 8'h00);
    check8("rma_wr_data", wr_data, 8'h00);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(10);
    bus_start();
    send_byte(8'h42, ack); check1("rma_post_addr_ack", ack, 1'b1);
    send_byte(8'h12, ack);
    bus_start();
    send_byte(8'h43, ack);
    read_byte(rb, 1'b0); check8("rma_reg12_reset", rb, 8'h00);
    bus_stop();
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h01, ack);
    bus_start();
    send_byte(8'h43, ack);
    read_byte(rb, 1'b0); check8("rma_reg01_reset", rb, 8'h00);
    bus_stop();

    wait_clk(5);
    check8("sb_drained", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
